// File: rtl/ultrasonic_array.sv
// Round-robin controller for N HC-SR04-class ultrasonic sensors: fires one trigger
// at a time, times the echo pulse, flags timeouts and scales the width to millimetres.
module ultrasonic_array #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 24,
    parameter int TRIG_CYCLES  = 500,
    parameter int RISE_TIMEOUT = 1_500_000,
    parameter int MAX_ECHO     = 1_250_000,
    parameter int HOLDOFF      = 3_000_000,
    parameter int SCALE_Q16    = 225,
    parameter int DIST_W       = 16,
    localparam int AW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trigger,
    output logic [N_CH*DIST_W-1:0]   dist_mm,
    output logic [N_CH-1:0]          valid,
    output logic [N_CH-1:0]          timeout,
    output logic [AW-1:0]            active_ch,
    output logic                     busy
);

    localparam int PW = CNT_W + 17;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(MAX_ECHO - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
    localparam logic [AW-1:0]    LAST_CH   = AW'(N_CH - 1);
    localparam logic [PW-1:0]    SCALE     = PW'(SCALE_Q16);
    localparam logic [PW-1:0]    DIST_MAX  = PW'({DIST_W{1'b1}});

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_CONVERT,
        ST_HOLDOFF
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]          ch_q, ch_d;
    logic [N_CH*DIST_W-1:0] dist_q, dist_d;
    logic [N_CH-1:0]        timeout_q, timeout_d;
    logic [N_CH-1:0]        valid_q, valid_d;

    logic [N_CH-1:0]        echo_s1_q, echo_s2_q, echo_s3_q;

    logic                   echo_cur;
    logic                   echo_rise;
    logic [CNT_W-1:0]       cnt_inc;
    logic [PW-1:0]          prod;
    logic [PW-1:0]          scaled;
    logic [DIST_W-1:0]      conv;

    // Two flops resynchronise the asynchronous echo lines; the third holds the
    // previous synchronised value for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_s1_q <= '0;
            echo_s2_q <= '0;
            echo_s3_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts by exactly one stage per clock.
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
        end
    end

    // Only the served channel is looked at, which is what rejects crosstalk.
    assign echo_cur  = echo_s2_q[ch_q];
    assign echo_rise = echo_s2_q[ch_q] & ~echo_s3_q[ch_q];
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        prod   = PW'(cnt_q) * SCALE;
        scaled = prod >> 16;
        conv   = (scaled > DIST_MAX) ? {DIST_W{1'b1}} : scaled[DIST_W-1:0];
    end

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        dist_d    = dist_q;
        timeout_d = timeout_q;
        valid_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable || start) begin
                    state_d = ST_TRIG;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            end

            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                end else if (cnt_q == RISE_LAST) begin
                    timeout_d[ch_q] = 1'b1;
                    valid_d[ch_q]   = 1'b1;
                    state_d         = ST_HOLDOFF;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_MEASURE: begin
                if (!echo_cur) begin
                    state_d = ST_CONVERT;
                end else if (cnt_q == ECHO_LAST) begin
                    timeout_d[ch_q] = 1'b1;
                    valid_d[ch_q]   = 1'b1;
                    state_d         = ST_HOLDOFF;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_CONVERT: begin
                dist_d[int'(ch_q)*DIST_W +: DIST_W] = conv;
                timeout_d[ch_q] = 1'b0;
                valid_d[ch_q]   = 1'b1;
                state_d         = ST_HOLDOFF;
                cnt_d           = '0;
            end

            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (ch_q < LAST_CH) begin
                        ch_d    = ch_q + AW'(1);
                        state_d = ST_TRIG;
                    end else if (enable) begin
                        ch_d    = '0;
                        state_d = ST_TRIG;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            dist_q    <= '0;
            timeout_q <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            dist_q    <= dist_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
        end
    end

    // Trigger is decoded straight from the state register so reset kills it at once.
    always_comb begin
        trigger = '0;
        if (state_q == ST_TRIG) begin
            trigger[ch_q] = 1'b1;
        end
    end

    assign dist_mm   = dist_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign active_ch = ch_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_array.sv
// Directed bench for ultrasonic_array: behavioural echo responder, per-feature tasks,
// and a second instance with an 8-bit distance width for saturation.
module tb_ultrasonic_array;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            start;
    logic [N-1:0]    echo_mdl;
    logic [N-1:0]    echo_xtra;
    logic [N-1:0]    echo_bus;
    logic [N-1:0]    trigger;
    logic [N*DW-1:0] dist_mm;
    logic [N-1:0]    valid;
    logic [N-1:0]    timeout;
    logic [1:0]      active_ch;
    logic            busy;

    logic            enable_sat;
    logic            start_sat;
    logic [N-1:0]    echo_sat;
    logic [N-1:0]    trigger_sat;
    logic [N*8-1:0]  dist_sat;
    logic [N-1:0]    valid_sat;
    logic [N-1:0]    timeout_sat;
    logic [1:0]      active_ch_sat;
    logic            busy_sat;

    int checks;
    int errors;

    int w_tab[4];
    int valid_cnt[4];
    int trig_order[$];
    int trig_bad_len;
    int multi_hot;

    assign echo_bus = echo_mdl | echo_xtra;

    ultrasonic_array #(
        .N_CH(4), .CNT_W(24), .TRIG_CYCLES(10), .RISE_TIMEOUT(200), .MAX_ECHO(1000),
        .HOLDOFF(20), .SCALE_Q16(65536), .DIST_W(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .echo(echo_bus),
        .trigger(trigger), .dist_mm(dist_mm), .valid(valid), .timeout(timeout),
        .active_ch(active_ch), .busy(busy)
    );

    ultrasonic_array #(
        .N_CH(4), .CNT_W(24), .TRIG_CYCLES(10), .RISE_TIMEOUT(200), .MAX_ECHO(1000),
        .HOLDOFF(20), .SCALE_Q16(65536), .DIST_W(8)
    ) dut_sat (
        .clk(clk), .reset(reset), .enable(enable_sat), .start(start_sat), .echo(echo_sat),
        .trigger(trigger_sat), .dist_mm(dist_sat), .valid(valid_sat), .timeout(timeout_sat),
        .active_ch(active_ch_sat), .busy(busy_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Echo responder: 5 cycles after a channel's trigger falls, hold echo high for w_tab[k] cycles (0 = silent).
    initial begin
        int dly[4];
        int hi[4];
        logic [N-1:0] tp;
        echo_mdl = '0;
        tp = '0;
        for (int k = 0; k < N; k++) begin
            dly[k] = 0;
            hi[k] = 0;
            w_tab[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (tp[k] && !trigger[k] && w_tab[k] > 0) begin
                    dly[k] = 5;
                end else if (dly[k] > 0) begin
                    dly[k]--;
                    if (dly[k] == 0) begin
                        echo_mdl[k] = 1'b1;
                        hi[k] = w_tab[k];
                    end
                end else if (hi[k] > 0) begin
                    hi[k]--;
                    if (hi[k] == 0) echo_mdl[k] = 1'b0;
                end
            end
            tp = trigger;
        end
    end

    // Trigger/valid monitor: order of trigger pulses, their widths, one-hot property, valid pulse counts.
    initial begin
        logic [N-1:0] prev;
        int len;
        prev = '0;
        len = 0;
        trig_bad_len = 0;
        multi_hot = 0;
        for (int k = 0; k < N; k++) valid_cnt[k] = 0;
        forever begin
            @(negedge clk);
            if ($countones(trigger) > 1) multi_hot++;
            for (int k = 0; k < N; k++) if (valid[k]) valid_cnt[k]++;
            if (trigger != '0) begin
                if (prev == '0) begin
                    for (int k = 0; k < N; k++) if (trigger[k]) trig_order.push_back(k);
                    len = 0;
                end
                len++;
            end else if (prev != '0 && len != 10) begin
                trig_bad_len++;
            end
            prev = trigger;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int dist_of(input int k);
        return int'(dist_mm[k*DW +: DW]);
    endfunction

    task automatic clear_mon();
        trig_order.delete();
        trig_bad_len = 0;
        multi_hot = 0;
        for (int k = 0; k < N; k++) valid_cnt[k] = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", tag, busy, budget);
        end
    endtask

    task automatic run_sweep(input int w0, input int w1, input int w2, input int w3, input string tag);
        w_tab = '{w0, w1, w2, w3};
        clear_mon();
        pulse_start();
        wait_idle(6000, tag);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        echo_xtra = '1;
        repeat (5) @(negedge clk);
        checks++; if (trigger !== 4'b0)   begin errors++; $display("FAIL reset_trigger: got %b want 0000", trigger); end
        checks++; if (dist_mm !== '0)     begin errors++; $display("FAIL reset_dist: got %h want 0", dist_mm); end
        checks++; if (valid !== 4'b0)     begin errors++; $display("FAIL reset_valid: got %b want 0000", valid); end
        checks++; if (timeout !== 4'b0)   begin errors++; $display("FAIL reset_timeout: got %b want 0000", timeout); end
        checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active_ch: got %0d want 0", active_ch); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        echo_xtra = '0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        checks++; if (trigger !== 4'b0)   begin errors++; $display("FAIL post_reset_trigger: got %b want 0000", trigger); end
    endtask

    task automatic test_single_sweep();
        w_tab = '{100, 200, 300, 400};
        clear_mon();
        pulse_start();
        checks++; if (trigger !== 4'b0001) begin errors++; $display("FAIL start_to_trigger: got %b want 0001", trigger); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
        wait_idle(6000, "single_sweep");
        checks++;
        if (trig_order.size() != 4) begin
            errors++;
            $display("FAIL sweep_trig_count: got %0d want 4", trig_order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (trig_order[k] != k) begin errors++; $display("FAIL sweep_order[%0d]: got %0d want %0d", k, trig_order[k], k); end
            end
        end
        checks++; if (trig_bad_len != 0) begin errors++; $display("FAIL trig_width: %0d pulses not 10 cycles, want 0", trig_bad_len); end
        checks++; if (multi_hot != 0)    begin errors++; $display("FAIL trig_onehot: %0d multi-hot cycles, want 0", multi_hot); end
        for (int k = 0; k < 4; k++) begin
            int want = 100 * (k + 1);
            checks++;
            if (valid_cnt[k] != 1) begin errors++; $display("FAIL sweep_valid[%0d]: got %0d pulses want 1", k, valid_cnt[k]); end
            checks++;
            if (dist_of(k) < want - 1 || dist_of(k) > want + 1) begin
                errors++; $display("FAIL sweep_dist[%0d]: got %0d want %0d+-1", k, dist_of(k), want);
            end
        end
        checks++; if (timeout !== 4'b0) begin errors++; $display("FAIL sweep_timeout: got %b want 0000", timeout); end
    endtask

    task automatic test_timeouts();
        int want[4];
        run_sweep(60, 70, 80, 90, "to_prep");
        w_tab = '{60, 0, 1500, 90};
        clear_mon();
        pulse_start();
        wait_idle(6000, "timeout_sweep");
        want = '{60, 70, 80, 90};
        checks++; if (timeout !== 4'b0110) begin errors++; $display("FAIL timeout_bits: got %b want 0110", timeout); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dist_of(k) < want[k] - 1 || dist_of(k) > want[k] + 1) begin
                errors++; $display("FAIL timeout_dist[%0d]: got %0d want %0d+-1", k, dist_of(k), want[k]);
            end
            checks++;
            if (valid_cnt[k] != 1) begin errors++; $display("FAIL timeout_valid[%0d]: got %0d pulses want 1", k, valid_cnt[k]); end
        end
        repeat (700) @(negedge clk);
        run_sweep(100, 200, 300, 400, "to_clear");
        checks++; if (timeout !== 4'b0000) begin errors++; $display("FAIL timeout_cleared: got %b want 0000", timeout); end
        checks++;
        if (dist_of(2) < 299 || dist_of(2) > 301) begin errors++; $display("FAIL timeout_recover_dist2: got %0d want 300+-1", dist_of(2)); end
    endtask

    task automatic test_crosstalk();
        int n = 0;
        w_tab = '{120, 80, 80, 80};
        clear_mon();
        pulse_start();
        while (!(active_ch == 2'd0 && echo_bus[0]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(active_ch == 2'd0 && echo_bus[0])) begin errors++; $display("FAIL xtalk_reach_measure: ch0 echo not seen within 200 cycles"); end
        for (int i = 0; i < 8; i++) begin
            echo_xtra[3] = ~echo_xtra[3];
            repeat (5) @(negedge clk);
        end
        echo_xtra = '0;
        wait_idle(6000, "crosstalk");
        checks++;
        if (dist_of(0) < 119 || dist_of(0) > 121) begin errors++; $display("FAIL xtalk_dist0: got %0d want 120+-1", dist_of(0)); end
        checks++;
        if (dist_of(3) < 79 || dist_of(3) > 81) begin errors++; $display("FAIL xtalk_dist3: got %0d want 80+-1", dist_of(3)); end
        checks++; if (timeout !== 4'b0) begin errors++; $display("FAIL xtalk_timeout: got %b want 0000", timeout); end
    endtask

    task automatic test_echo_preheld();
        echo_xtra = 4'b0001;
        repeat (5) @(negedge clk);
        run_sweep(0, 100, 100, 100, "preheld");
        echo_xtra = '0;
        checks++; if (timeout !== 4'b0001) begin errors++; $display("FAIL preheld_timeout: got %b want 0001", timeout); end
        checks++;
        if (dist_of(0) < 119 || dist_of(0) > 121) begin errors++; $display("FAIL preheld_dist0: got %0d want 120+-1 (unchanged)", dist_of(0)); end
        checks++;
        if (valid_cnt[0] != 1) begin errors++; $display("FAIL preheld_valid0: got %0d pulses want 1", valid_cnt[0]); end
    endtask

    task automatic test_mode_control();
        int n = 0;
        int n0;
        w_tab = '{50, 50, 50, 50};
        clear_mon();
        @(negedge clk);
        enable = 1'b1;
        while (trig_order.size() < 6 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (trig_order.size() < 6) begin
            errors++; $display("FAIL mode_wrap_count: got %0d triggers want >=6", trig_order.size());
        end else begin
            checks++;
            if (trig_order[4] != 0 || trig_order[5] != 1) begin
                errors++; $display("FAIL mode_wrap_order: got %0d,%0d want 0,1", trig_order[4], trig_order[5]);
            end
        end
        n = 0;
        while (!(active_ch == 2'd2 && trigger == 4'b0 && echo_bus[2]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(active_ch == 2'd2 && echo_bus[2])) begin errors++; $display("FAIL mode_reach_ch2: ch2 echo not seen within 2000 cycles"); end
        enable = 1'b0;
        n0 = trig_order.size();
        pulse_start();
        wait_idle(3000, "mode_drop");
        checks++;
        if (trig_order.size() != n0 + 1 || trig_order[trig_order.size()-1] != 3) begin
            errors++; $display("FAIL mode_finish_sweep: got %0d extra triggers (last ch %0d) want 1 (ch 3)",
                               trig_order.size() - n0, trig_order[trig_order.size()-1]);
        end
        repeat (100) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode_stay_idle: busy=%b want 0", busy); end
        checks++;
        if (trig_order.size() != n0 + 1) begin errors++; $display("FAIL mode_no_extra_sweep: got %0d triggers want %0d", trig_order.size(), n0 + 1); end
    endtask

    task automatic test_saturation();
        int n = 0;
        int seen = 0;
        @(negedge clk);
        start_sat = 1'b1;
        @(negedge clk);
        start_sat = 1'b0;
        checks++; if (active_ch_sat !== 2'd0) begin errors++; $display("FAIL sat_active_ch: got %0d want 0", active_ch_sat); end
        while (trigger_sat[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++; if (trigger_sat[0] !== 1'b0) begin errors++; $display("FAIL sat_trig_end: trigger still high after 50 cycles"); end
        repeat (5) @(negedge clk);
        echo_sat[0] = 1'b1;
        repeat (300) @(negedge clk);
        echo_sat[0] = 1'b0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (valid_sat[0]) seen = 1;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL sat_valid: no valid pulse within 20 cycles, want 1"); end
        checks++; if (dist_sat[7:0] !== 8'd255) begin errors++; $display("FAIL sat_dist0: got %0d want 255", dist_sat[7:0]); end
        n = 0;
        while (busy_sat && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (busy_sat !== 1'b0) begin errors++; $display("FAIL sat_idle: busy=%b want 0", busy_sat); end
        checks++; if (timeout_sat !== 4'b1110) begin errors++; $display("FAIL sat_timeout: got %b want 1110", timeout_sat); end
        checks++; if (dist_sat[31:8] !== 24'd0) begin errors++; $display("FAIL sat_other_dist: got %h want 0", dist_sat[31:8]); end
    endtask

    task automatic test_async_reset();
        w_tab = '{100, 100, 100, 100};
        pulse_start();
        repeat (3) @(negedge clk);
        checks++; if (trigger !== 4'b0001) begin errors++; $display("FAIL areset_pre_trigger: got %b want 0001", trigger); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (trigger !== 4'b0) begin errors++; $display("FAIL areset_trigger: got %b want 0000", trigger); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++; if (dist_mm !== '0)   begin errors++; $display("FAIL areset_dist: got %h want 0", dist_mm); end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL areset_after: busy=%b want 0", busy); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        enable     = 1'b0;
        start      = 1'b0;
        echo_xtra  = '0;
        enable_sat = 1'b0;
        start_sat  = 1'b0;
        echo_sat   = '0;

        test_reset();
        test_single_sweep();
        test_timeouts();
        test_crosstalk();
        test_echo_preheld();
        test_mode_control();
        test_saturation();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
